sha256_state_machine: RTL and testbench

//  Single-block SHA-256 hasher with a 4-state control FSM. Pads a fixed-width

---
 rtl/sha256_state_machine.sv | 176 +++++++++++++++++
 tb/tb_sha256_state_machine.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_state_machine.sv
// Single-block SHA-256 engine: pads a MSG_SIZE-bit message, runs 64 rounds, holds the digest.
// Optional one-cycle done pulse on DONE entry when SHA256_DONE_PULSE_EN is defined.
module sha256_state_machine #(
  parameter int unsigned MSG_SIZE        = 88,
  parameter int unsigned PADDED_MSG_SIZE = 512
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [MSG_SIZE-1:0] inputMsg,
  output logic                q_start,
  output logic [1:0]          q_state,
`ifdef SHA256_DONE_PULSE_EN
  output logic                done,
`endif
  output logic [255:0]        hashOutput
);

  if (MSG_SIZE > 447 || MSG_SIZE < 8 || (MSG_SIZE % 8) != 0 || PADDED_MSG_SIZE != 512)
  begin : g_cfg_error
    $error("sha256_state_machine: unsupported MSG_SIZE/PADDED_MSG_SIZE");
  end

  typedef enum logic [1:0] {
    StReset = 2'b00,
    StIdle  = 2'b01,
    StProc  = 2'b10,
    StDone  = 2'b11
  } state_e;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  state_e        state_q, state_d;
  logic          start_q;
  logic [5:0]    t_q, t_d;
  logic [31:0]   w_q [16];
  logic [31:0]   w_d [16];
  logic [31:0]   v_q [8];
  logic [31:0]   v_d [8];
  logic [31:0]   h_q [8];
  logic [31:0]   h_d [8];
  logic [255:0]  hash_q, hash_d;
  logic [511:0]  block;
  logic [31:0]   round_v [8];
  logic [31:0]   w_next;
  logic          launch;

  assign launch     = start && !start_q;
  assign q_start    = start_q;
  assign q_state    = state_q;
  assign hashOutput = hash_q;

  always_comb begin
    block = '0;
    block[511 -: MSG_SIZE]  = inputMsg;
    block[511 - MSG_SIZE]   = 1'b1;
    block[63:0]             = 64'(MSG_SIZE);
  end

  // One compression round on the working variables, plus W[t+16] for the sliding window.
  always_comb begin
    logic [31:0] s0, s1, ch, maj, t1, t2;
    s1  = rotr(v_q[4], 6) ^ rotr(v_q[4], 11) ^ rotr(v_q[4], 25);
    ch  = (v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6]);
    t1  = v_q[7] + s1 + ch + K[t_q] + w_q[0];
    s0  = rotr(v_q[0], 2) ^ rotr(v_q[0], 13) ^ rotr(v_q[0], 22);
    maj = (v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]);
    t2  = s0 + maj;
    round_v[0] = t1 + t2;
    round_v[1] = v_q[0];
    round_v[2] = v_q[1];
    round_v[3] = v_q[2];
    round_v[4] = v_q[3] + t1;
    round_v[5] = v_q[4];
    round_v[6] = v_q[5];
    round_v[7] = v_q[6];
    w_next = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9] +
             (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    w_d     = w_q;
    v_d     = v_q;
    h_d     = h_q;
    hash_d  = hash_q;
    unique case (state_q)
      StReset: state_d = StIdle;
      StIdle: begin
        if (launch) begin
          for (int i = 0; i < 16; i++) w_d[i] = block[511 - 32*i -: 32];
          v_d     = IV;
          h_d     = IV;
          t_d     = 6'd0;
          state_d = StProc;
        end
      end
      StProc: begin
        v_d = round_v;
        for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
        w_d[15] = w_next;
        t_d     = t_q + 6'd1;
        if (t_q == 6'd63) begin
          for (int i = 0; i < 8; i++) begin
            h_d[i] = h_q[i] + round_v[i];
            hash_d[255 - 32*i -: 32] = h_q[i] + round_v[i];
          end
          state_d = StDone;
        end
      end
      StDone: begin
        if (!start) state_d = StIdle;
      end
      default: state_d = StReset;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StReset;
      start_q <= 1'b0;
      t_q     <= 6'd0;
      hash_q  <= '0;
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
      for (int i = 0; i < 8; i++) begin
        v_q[i] <= '0;
        h_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      start_q <= start;
      t_q     <= t_d;
      hash_q  <= hash_d;
      w_q     <= w_d;
      v_q     <= v_d;
      h_q     <= h_d;
    end
  end

`ifdef SHA256_DONE_PULSE_EN
  logic done_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) done_q <= 1'b0;
    else       done_q <= (state_q == StProc) && (t_q == 6'd63);
  end
  assign done = done_q;
`endif

endmodule

// File: tb/tb_sha256_state_machine.sv
// Bench for sha256_state_machine: two instances (88-bit and 24-bit messages) checked every
// cycle against a protocol model whose digests come from a whole-message SHA-256 function.
module tb_sha256_state_machine;

  localparam logic [255:0] HELLO_DIGEST =
    256'hb94d27b9934d3e08a52e52d7da7dabfac484efe37a5380ee9088f7ace2efcde9;
  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] IVT [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  logic         clk;
  logic         reset;
  logic         start;
  logic [87:0]  msg_a;
  logic [23:0]  msg_b;
  logic         q_start_a, q_start_b;
  logic [1:0]   q_state_a, q_state_b;
  logic [255:0] hash_a, hash_b;
`ifdef SHA256_DONE_PULSE_EN
  logic         done_a, done_b;
`endif

  int checks   = 0;
  int failures = 0;

  sha256_state_machine #(.MSG_SIZE(88), .PADDED_MSG_SIZE(512)) dut_a (
    .clk(clk), .reset(reset), .start(start), .inputMsg(msg_a),
    .q_start(q_start_a), .q_state(q_state_a),
`ifdef SHA256_DONE_PULSE_EN
    .done(done_a),
`endif
    .hashOutput(hash_a)
  );

  sha256_state_machine #(.MSG_SIZE(24), .PADDED_MSG_SIZE(512)) dut_b (
    .clk(clk), .reset(reset), .start(start), .inputMsg(msg_b),
    .q_start(q_start_b), .q_state(q_state_b),
`ifdef SHA256_DONE_PULSE_EN
    .done(done_b),
`endif
    .hashOutput(hash_b)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Whole-message reference hash; msg is left-aligned, nbytes <= 55.
  function automatic logic [255:0] sha256_ref(input logic [439:0] msg, input int nbytes);
    logic [7:0]   blk [64];
    logic [31:0]  w [64];
    logic [31:0]  hv [8];
    logic [31:0]  a, b, c, d, e, f, g, h, t1, t2;
    logic [63:0]  bitlen;
    logic [255:0] r;
    for (int i = 0; i < 64; i++) blk[i] = 8'h00;
    for (int i = 0; i < nbytes; i++) blk[i] = msg[439 - 8*i -: 8];
    blk[nbytes] = 8'h80;
    bitlen = 64'(nbytes * 8);
    for (int i = 0; i < 8; i++) blk[56 + i] = bitlen[63 - 8*i -: 8];
    for (int t = 0; t < 16; t++) w[t] = {blk[4*t], blk[4*t+1], blk[4*t+2], blk[4*t+3]};
    for (int t = 16; t < 64; t++)
      w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7] +
             (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    hv = IVT;
    {a, b, c, d, e, f, g, h} = {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], hv[7]};
    for (int t = 0; t < 64; t++) begin
      t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
      t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      {a, b, c, d, e, f, g, h} = {t1 + t2, a, b, c, d + t1, e, f, g};
    end
    hv[0] += a; hv[1] += b; hv[2] += c; hv[3] += d;
    hv[4] += e; hv[5] += f; hv[6] += g; hv[7] += h;
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hv[i];
    return r;
  endfunction

  // Protocol model: state 0 reset, 1 idle, 2 hashing, 3 done.
  int           m_st [2]   = '{0, 0};
  int           m_cnt [2]  = '{0, 0};
  logic [255:0] m_tgt [2]  = '{'0, '0};
  logic [255:0] m_hash [2] = '{'0, '0};
  logic         m_done [2] = '{1'b0, 1'b0};
  logic         m_qs       = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_st[i] = 0; m_cnt[i] = 0; m_hash[i] = '0; m_done[i] = 1'b0;
      end
      m_qs = 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_done[i] = 1'b0;
        case (m_st[i])
          0: m_st[i] = 1;
          1: if (start && !m_qs) begin
               m_tgt[i] = (i == 0) ? sha256_ref({msg_a, 352'b0}, 11)
                                   : sha256_ref({msg_b, 416'b0}, 3);
               m_cnt[i] = 0;
               m_st[i]  = 2;
             end
          2: begin
               m_cnt[i]++;
               if (m_cnt[i] == 64) begin
                 m_st[i] = 3; m_hash[i] = m_tgt[i]; m_done[i] = 1'b1;
               end
             end
          default: if (!start) m_st[i] = 1;
        endcase
      end
      m_qs = start;
    end
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic compare_cycle();
    chk("state_a", 256'(q_state_a), 256'(m_st[0]));
    chk("state_b", 256'(q_state_b), 256'(m_st[1]));
    chk("hash_a", hash_a, m_hash[0]);
    chk("hash_b", hash_b, m_hash[1]);
    chk("q_start_a", 256'(q_start_a), 256'(m_qs));
    chk("q_start_b", 256'(q_start_b), 256'(m_qs));
`ifdef SHA256_DONE_PULSE_EN
    chk("done_a", 256'(done_a), 256'(m_done[0]));
    chk("done_b", 256'(done_b), 256'(m_done[1]));
`endif
  endtask

  task automatic wait_done_a(output int n);
    n = 0;
    while (q_state_a != 2'b11 && n < 100) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int lat;
    reset = 1'b1;
    start = 1'b0;
    msg_a = "hello world";
    msg_b = "abc";
    fork
      forever begin
        @(negedge clk);
        compare_cycle();
      end
    join_none

    chk("ref_hello", sha256_ref({msg_a, 352'b0}, 11), HELLO_DIGEST);
    chk("ref_abc", sha256_ref({msg_b, 416'b0}, 3), ABC_DIGEST);

    cycles(3);
    reset = 1'b0;
    chk("reset_state", 256'(q_state_a), 256'(0));
    chk("reset_hash", hash_a, 256'(0));
    cycles(1);
    chk("idle_after_reset", 256'(q_state_a), 256'(1));
    cycles(2);

    // First launch; message changes mid-hash must not matter.
    start = 1'b1;
    fork
      begin cycles(10); msg_a = "HELLO WORLD"; msg_b = "xyz"; end
    join_none
    wait_done_a(lat);
    chk("latency_a", 256'(lat), 256'(65));
    chk("digest_hello", hash_a, HELLO_DIGEST);
    chk("digest_abc", hash_b, ABC_DIGEST);

    // Held start after DONE: no relaunch.
    cycles(10);
    chk("hold_done_state", 256'(q_state_a), 256'(3));
    start = 1'b0;
    cycles(1);
    chk("back_to_idle", 256'(q_state_a), 256'(1));
    chk("hash_kept", hash_a, HELLO_DIGEST);
    msg_a = "hello world";
    msg_b = "abc";
    cycles(2);

    // Short toggles: second edge falls inside the hash and is ignored.
    for (int k = 0; k < 2; k++) begin
      start = 1'b1; cycles(8);
      start = 1'b0; cycles(8);
    end
    cycles(60);
    chk("toggle_short_idle", 256'(q_state_a), 256'(1));

    // Long toggles: two full hashes.
    for (int k = 0; k < 2; k++) begin
      start = 1'b1; cycles(80);
      chk("toggle_long_done", 256'(q_state_a), 256'(3));
      start = 1'b0; cycles(4);
    end
    chk("toggle_digest", hash_a, HELLO_DIGEST);

    // Reset mid-hash, then a clean relaunch.
    start = 1'b1;
    cycles(31);
    #5 reset = 1'b1;
    #1;
    chk("abort_state", 256'(q_state_a), 256'(0));
    chk("abort_hash", hash_a, 256'(0));
    chk("abort_q_start", 256'(q_start_a), 256'(0));
    cycles(2);
    reset = 1'b0;
    start = 1'b0;
    cycles(3);
    start = 1'b1;
    wait_done_a(lat);
    chk("latency_relaunch", 256'(lat), 256'(65));
    chk("digest_relaunch", hash_a, HELLO_DIGEST);
    chk("digest_relaunch_b", hash_b, ABC_DIGEST);
    start = 1'b0;
    cycles(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
